// File: rtl/nn_sample_engine.sv
// Responder side of the Control train/validate handshake: fetches one sample at a time,
// waits for the datapath to finish it, then strobes S_Train or S_Error.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------------
//  ST_IDLE   | no mode active; Error holds the last validation total
//  ST_FETCH  | SAMPLE_RD asserted for SAMPLE_ADDR, wait counter cleared
//  ST_WAIT   | waiting for FWD_DONE, abort on mode drop, abort on timeout
//  ST_REPORT | strobe for the finished sample, address advances
module nn_sample_engine #(
    parameter int BITS    = 16,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              TR,
    input  logic              VL,
    input  logic [ADDR_W-1:0] TRAIN_BASE,
    input  logic [ADDR_W-1:0] VALID_BASE,
    input  logic              FWD_DONE,
    input  logic [BITS-1:0]   SAMPLE_ERR,
    output logic              SAMPLE_RD,
    output logic [ADDR_W-1:0] SAMPLE_ADDR,
    output logic              S_Train,
    output logic              S_Error,
    output logic [BITS-1:0]   Error,
    output logic              BUSY,
    output logic              TIMEOUT_O
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_REPORT = 2'd3;

    localparam logic [15:0] WAIT_TC = 16'(TIMEOUT);

    logic [1:0]  state;
    logic        mode_valid;
    logic [15:0] wait_cnt;
    logic [15:0] wait_nxt;
    logic        mode_req;
    logic        other_req;
    logic [BITS:0] err_sum;

    assign mode_req  = mode_valid ? VL : TR;
    assign other_req = mode_valid ? TR : VL;
    assign wait_nxt  = wait_cnt + 16'd1;
    assign err_sum   = {1'b0, Error} + {1'b0, SAMPLE_ERR};

    assign SAMPLE_RD = (state == ST_FETCH);
    assign S_Train   = (state == ST_REPORT) && !mode_valid;
    assign S_Error   = (state == ST_REPORT) && mode_valid;
    assign BUSY      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            mode_valid  <= 1'b0;
            wait_cnt    <= '0;
            SAMPLE_ADDR <= '0;
            Error       <= '0;
            TIMEOUT_O   <= 1'b0;
        end else begin
            TIMEOUT_O <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (TR) begin
                        SAMPLE_ADDR <= TRAIN_BASE;
                        mode_valid  <= 1'b0;
                        state       <= ST_FETCH;
                    end else if (VL) begin
                        SAMPLE_ADDR <= VALID_BASE;
                        Error       <= '0;
                        mode_valid  <= 1'b1;
                        state       <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!mode_req) begin
                        state <= ST_IDLE;
                    end else if (FWD_DONE) begin
                        // Error is already final when the strobe is seen.
                        if (mode_valid)
                            Error <= err_sum[BITS] ? {BITS{1'b1}} : err_sum[BITS-1:0];
                        state <= ST_REPORT;
                    end else begin
                        wait_cnt <= wait_nxt;
                        if (wait_nxt == WAIT_TC) begin
                            TIMEOUT_O <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    SAMPLE_ADDR <= SAMPLE_ADDR + ADDR_W'(1);
                    // A mode switch goes through IDLE so the new base and Error clear apply.
                    if (mode_req && !other_req)
                        state <= ST_FETCH;
                    else
                        state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_sample_engine.sv
// Directed + randomized bench for nn_sample_engine; expectations come from a
// transaction-level model (address sequence, saturating error total).
module tb_nn_sample_engine;
    localparam int BITS = 16;
    localparam int AW   = 10;
    localparam int TO   = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            TR;
    logic            VL;
    logic [AW-1:0]   TRAIN_BASE;
    logic [AW-1:0]   VALID_BASE;
    logic            FWD_DONE;
    logic [BITS-1:0] SAMPLE_ERR;
    logic            SAMPLE_RD;
    logic [AW-1:0]   SAMPLE_ADDR;
    logic            S_Train;
    logic            S_Error;
    logic [BITS-1:0] Error;
    logic            BUSY;
    logic            TIMEOUT_O;

    nn_sample_engine #(.BITS(BITS), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .TR(TR), .VL(VL),
        .TRAIN_BASE(TRAIN_BASE), .VALID_BASE(VALID_BASE),
        .FWD_DONE(FWD_DONE), .SAMPLE_ERR(SAMPLE_ERR),
        .SAMPLE_RD(SAMPLE_RD), .SAMPLE_ADDR(SAMPLE_ADDR),
        .S_Train(S_Train), .S_Error(S_Error), .Error(Error),
        .BUSY(BUSY), .TIMEOUT_O(TIMEOUT_O)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int exp_err  = 0;
    int exp_addr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Advance until SAMPLE_RD; a conforming design shows it on the first cycle.
    task automatic wait_rd(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!SAMPLE_RD && n < 12);
        chk({tag, "_rd_latency"}, n, 1);
    endtask

    // One pass of n samples. both=1 raises TR and VL together (train must win).
    task automatic session(input bit valid, input bit both, input int base, input int n,
                           input int fixed_err, input int fixed_dly);
        bit vmode;
        int dly;
        int err;
        vmode = valid && !both;
        TRAIN_BASE = AW'($urandom);
        VALID_BASE = AW'($urandom);
        if (vmode) VALID_BASE = AW'(base);
        else       TRAIN_BASE = AW'(base);
        TR = !vmode;
        VL = vmode || both;
        exp_addr = base;
        if (vmode) exp_err = 0;
        for (int i = 0; i < n; i++) begin
            wait_rd("sess");
            chk("sample_addr", SAMPLE_ADDR, exp_addr);
            exp_addr = (exp_addr + 1) % (1 << AW);
            dly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 5));
            tick();
            repeat (dly) tick();
            chk("no_early_strobe", {BUSY, SAMPLE_RD, S_Train, S_Error}, 4'b1000);
            err = (fixed_err >= 0) ? fixed_err : int'($urandom_range(0, 65535));
            FWD_DONE   = 1'b1;
            SAMPLE_ERR = BITS'(err);
            if (vmode) exp_err = (exp_err + err > 65535) ? 65535 : exp_err + err;
            tick();
            FWD_DONE   = 1'b0;
            SAMPLE_ERR = BITS'($urandom);
            chk("strobes", {S_Train, S_Error}, {!vmode, vmode});
            chk("error_total", Error, exp_err);
        end
        TR = 1'b0;
        VL = 1'b0;
        tick();
        chk("end_idle_busy", BUSY, 0);
        chk("end_error_hold", Error, exp_err);
    endtask

    initial begin
        int n;
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit v;
        rst = 1'b1; TR = 1'b0; VL = 1'b0; FWD_DONE = 1'b0;
        SAMPLE_ERR = '0; TRAIN_BASE = '0; VALID_BASE = '0;
        tick(); tick();
        chk("reset_outputs", {SAMPLE_RD, S_Train, S_Error, BUSY, TIMEOUT_O, SAMPLE_ADDR, Error}, 0);
        rst = 1'b0;
        tick();
        chk("idle_after_reset", BUSY, 0);

        session(1'b0, 1'b0, 'h010, 4, -1, 2);
        session(1'b1, 1'b0, 'h100, 5, 2, -1);
        session(1'b1, 1'b0, int'($urandom_range(0, 1023)), 2, 'hFFF0, -1);
        session(1'b0, 1'b1, 'h055, 1, -1, -1);
        session(1'b0, 1'b0, 'h3FF, 2, -1, -1);

        // Train mode dropped in WAIT; late FWD_DONE must be ignored.
        TRAIN_BASE = 10'h020; TR = 1'b1;
        wait_rd("abort");
        tick();
        TR = 1'b0;
        tick();
        chk("abort_busy", BUSY, 0);
        FWD_DONE = 1'b1;
        tick();
        FWD_DONE = 1'b0;
        chk("abort_quiet", {S_Train, S_Error, SAMPLE_RD, BUSY}, 0);

        // Timeout: FETCH, then TO waiting cycles, then a one-cycle pulse in IDLE.
        TRAIN_BASE = 10'h0A5; TR = 1'b1;
        wait_rd("timeout");
        n = 0;
        do begin
            tick();
            n++;
        end while (!TIMEOUT_O && n < 30);
        chk("timeout_cycles", n, TO + 1);
        chk("timeout_idle", BUSY, 0);
        tick();
        chk("timeout_once", TIMEOUT_O, 0);
        chk("refetch_rd", SAMPLE_RD, 1);
        chk("refetch_addr", SAMPLE_ADDR, 'h0A5);
        TR = 1'b0;
        tick(); tick();
        chk("refetch_abort", BUSY, 0);

        // Mode switch in REPORT re-enters via IDLE, reloading base and clearing Error.
        TRAIN_BASE = 10'h111; VALID_BASE = 10'h222; TR = 1'b1;
        wait_rd("switch");
        tick();
        FWD_DONE = 1'b1;
        tick();
        FWD_DONE = 1'b0;
        chk("switch_train", {S_Train, S_Error}, 2'b10);
        VL = 1'b1;
        tick();
        chk("switch_idle", BUSY, 0);
        TR = 1'b0;
        wait_rd("switch_v");
        chk("switch_vbase", SAMPLE_ADDR, 'h222);
        chk("switch_clear", Error, 0);
        exp_err = 0;
        VL = 1'b0;
        tick(); tick();
        chk("switch_end", BUSY, 0);

        for (int k = 0; k < 16; k++) begin
            v = 1'($urandom);
            session(v, 1'b0, int'($urandom_range(0, 1023)), int'($urandom_range(1, 6)), -1, -1);
        end

        // Reset in validation WAIT clears everything, including Error.
        VALID_BASE = 10'h300; VL = 1'b1;
        exp_err = 0;
        wait_rd("rst");
        tick();
        FWD_DONE = 1'b1; SAMPLE_ERR = 16'd7;
        tick();
        FWD_DONE = 1'b0;
        chk("rst_pre_error", Error, 7);
        wait_rd("rst2");
        tick();
        rst = 1'b1;
        tick();
        chk("rst_midrun", {SAMPLE_RD, S_Train, S_Error, BUSY, TIMEOUT_O, SAMPLE_ADDR, Error}, 0);
        rst = 1'b0; VL = 1'b0;
        tick();
        chk("rst_idle", BUSY, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
